// File: rtl/ydemux4_frame.sv
`default_nettype none
// ============================================================================
// Module   : ydemux4_frame
// Purpose  : Collects a serial word stream into four lanes and holds the
//            completed frame until the consumer acknowledges it.
//            Optional YDEMUX4_SKID_EN: accept the next frame's first word in
//            the acknowledge cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ydemux4_frame #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    input  logic         frame_ack,
    output logic [W-1:0] z0,
    output logic [W-1:0] z1,
    output logic [W-1:0] z2,
    output logic [W-1:0] z3,
    output logic [3:0]   lane_fill,
    output logic         frame_valid
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_cnt;
    logic       w_ready;
    logic       w_xfer;

    // Ready never looks at in_valid, so the source may wait on it freely.
    always_comb begin
        w_ready = 1'b0;
        if (!flush) begin
            if (r_state == FILL) begin
                w_ready = 1'b1;
            end else begin
`ifdef YDEMUX4_SKID_EN
                w_ready = frame_ack;
`else
                w_ready = 1'b0;
`endif
            end
        end
    end

    assign in_ready = w_ready;
    assign w_xfer   = in_valid && w_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= FILL;
            r_cnt       <= 2'd0;
            z0          <= '0;
            z1          <= '0;
            z2          <= '0;
            z3          <= '0;
            lane_fill   <= 4'b0000;
            frame_valid <= 1'b0;
        end else if (flush) begin
            // Lane contents survive a flush; only the bookkeeping is cleared.
            r_state     <= FILL;
            r_cnt       <= 2'd0;
            lane_fill   <= 4'b0000;
            frame_valid <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_xfer) begin
                        case (r_cnt)
                            2'd0:    z0 <= in_data;
                            2'd1:    z1 <= in_data;
                            2'd2:    z2 <= in_data;
                            default: z3 <= in_data;
                        endcase
                        lane_fill[r_cnt] <= 1'b1;
                        r_cnt            <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state     <= HOLD;
                            frame_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (frame_ack) begin
                        r_state     <= FILL;
                        frame_valid <= 1'b0;
                        lane_fill   <= 4'b0000;
                        r_cnt       <= 2'd0;
`ifdef YDEMUX4_SKID_EN
                        if (w_xfer) begin
                            z0        <= in_data;
                            lane_fill <= 4'b0001;
                            r_cnt     <= 2'd1;
                        end
`endif
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ydemux4_frame.md
# ydemux4_frame

Four-lane frame collector: the receive-side counterpart of the 4-to-1 word multiplexer. Words arrive one per transfer on a shared W-bit bus. The block steers them in round-robin order into four registered lanes. When all four lanes hold data, it presents them as one parallel frame and holds it until the consumer acknowledges. It sits between a serialized word stream, for example one driven by a yMux4to1 under a select counter, and logic that needs all four words at once.

## Interface
- W, default 32: word width of the input bus and of each output lane.
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- in_data, input, W: incoming word.
- in_valid, input, 1: in_data is valid this cycle.
- in_ready, output, 1: the block accepts a word this cycle. A transfer happens when in_valid and in_ready are both high at a rising clk edge.
- flush, input, 1: synchronous abort. Discards the partial or held frame.
- frame_ack, input, 1: the consumer has taken the frame. Only meaningful while frame_valid is high.
- z0, z1, z2, z3, output, W each: lane registers, filled in order z0, z1, z2, z3.
- lane_fill, output, 4: bit i is high when lane i holds a word of the current frame.
- frame_valid, output, 1: all four lanes are filled and stable.

## Operation
- State machine with two states: FILL and HOLD. A 2-bit lane counter, cnt, selects the target lane.
- Reset values: state = FILL, cnt = 0, z0..z3 = 0, lane_fill = 0000, frame_valid = 0, in_ready = 1 (in_ready is asserted as soon as reset deasserts).
- FILL state:
  - in_ready = !flush.
  - On a transfer, lane[cnt] <= in_data, lane_fill[cnt] <= 1, cnt <= cnt + 1 (mod 4).
  - A transfer while cnt == 3 moves the block to HOLD and sets frame_valid.
  - Lanes not yet written in the current frame keep their previous values. Consumers must qualify lane data with lane_fill.
- HOLD state:
  - z0..z3 and lane_fill (1111) are frozen.
  - in_ready is low, except as described under Configuration.
  - frame_ack moves the block to FILL, clears frame_valid, sets lane_fill = 0000 and cnt = 0.
- flush, in any state:
  - Next cycle: state = FILL, cnt = 0, lane_fill = 0000, frame_valid = 0.
  - z0..z3 keep their values.
  - flush has priority over in_valid and frame_ack in the same cycle. No word is accepted and no ack is counted.
- frame_ack in FILL has no effect.
- in_valid while in_ready is low has no effect. The source must hold its word.
- cnt wraps from 3 to 0 only on entering HOLD. A fifth word can therefore never overwrite z0 before frame_ack.

## Timing
- Latency: z[cnt] and lane_fill[cnt] update on the edge that completes the transfer.
- frame_valid rises on the same edge that writes z3.
- Minimum frame period: 4 transfer cycles plus 1 HOLD cycle, when frame_ack is asserted in the first HOLD cycle (with the macro off).
- frame_valid falls on the edge after frame_ack is sampled high.
- in_ready is a combinational function of state, flush and frame_ack. in_ready does not depend on in_valid.
- Reset asserted mid-frame immediately forces all reset values, without waiting for a clock edge. The partial frame is lost.

## Configuration
- YDEMUX4_SKID_EN defined: in HOLD, in_ready = frame_ack && !flush. A transfer in the ack cycle writes z0 of the next frame. The next cycle shows state = FILL, cnt = 1, lane_fill = 0001, frame_valid = 0. Sustained throughput is 4 words per 4 cycles.
- YDEMUX4_SKID_EN not defined: in HOLD, in_ready = 0. The ack cycle is always a bubble, so throughput is 4 words per 5 cycles.

## Test plan
- Reset then a stream of four words: after reset, feed 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles with in_valid = 1 -> z0..z3 equal those words in order; frame_valid rises with z3; lane_fill reaches 1111; in_ready goes low.
- Gaps and hold: deassert in_valid between words and keep in_valid = 1 during HOLD for 3 cycles with 0xDEADBEEF on in_data -> no lane changes during HOLD; frame_valid stays high until frame_ack; then lane_fill = 0000 and in_ready = 1.
- Flush mid-frame: accept 0xA5A5A5A5 and 0x5A5A5A5A, then assert flush together with in_valid -> word not accepted; lane_fill = 0000, cnt = 0; the next word lands in z0.
- Flush against ack: in HOLD, assert flush and frame_ack together -> state FILL, frame_valid = 0, no word accepted.
- Asynchronous reset: assert reset between clock edges after 2 transfers -> outputs reach their reset values before the next edge; a subsequent 4-word frame completes normally.
- Macro comparison: 8 back-to-back words with frame_ack tied high -> with YDEMUX4_SKID_EN, both frames complete in 8 cycles; without it, in 9 cycles, with in_ready low in cycle 5.
